// File: rtl/rf_pkg.sv
// Shared types and address-mapping helpers for the banked GPGPU register file.
package rf_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    SECOND
  } rf_state_e;

  function automatic int rows_of(input int warp_addr, input int reg_addr, input int bank_addr);
    return 1 << (warp_addr + reg_addr - bank_addr);
  endfunction

  // Warp-swizzled bank select keeps the same register of neighbouring warps in different banks.
  function automatic int bank_of(input int warp, input int rg, input int bank_addr);
    return (warp + rg) & ((1 << bank_addr) - 1);
  endfunction

  function automatic int row_of(input int warp, input int rg, input int reg_addr, input int bank_addr);
    return (warp << (reg_addr - bank_addr)) | (rg >> bank_addr);
  endfunction

endpackage

// File: rtl/rf_bank.sv
// One simple dual-port register-file bank: combinational read port with write-first
// bypass, one synchronous write port.
module rf_bank #(
  parameter int DATA = 32,
  parameter int ROWS = 16,
  parameter int AW   = 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DATA-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [DATA-1:0] rdata
);

  logic [DATA-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];

endmodule

// File: rtl/gpgpu_banked_rf.sv
// Banked multi-warp operand register file with bank-conflict serialisation.
// Define RF_INIT_EN to zero-sweep all rows after reset before accepting reads.
module gpgpu_banked_rf
  import rf_pkg::*;
#(
  parameter int DATA      = 32,
  parameter int WARP_ADDR = 2,
  parameter int REG_ADDR  = 3,
  parameter int BANK_ADDR = 1,
  parameter int OREG      = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_valid,
  output logic                 rd_ready,
  input  logic [WARP_ADDR-1:0] rd_warp,
  input  logic [REG_ADDR-1:0]  rd_a_reg,
  input  logic [REG_ADDR-1:0]  rd_b_reg,
  output logic                 out_valid,
  output logic [DATA-1:0]      out_a,
  output logic [DATA-1:0]      out_b,
  input  logic                 wr_en,
  input  logic [WARP_ADDR-1:0] wr_warp,
  input  logic [REG_ADDR-1:0]  wr_reg,
  input  logic [DATA-1:0]      wr_data,
  output logic                 init_done
);

  localparam int NB   = 1 << BANK_ADDR;
  localparam int BW   = (BANK_ADDR > 0) ? BANK_ADDR : 1;
  localparam int RW   = WARP_ADDR + REG_ADDR - BANK_ADDR;
  localparam int ROWS = rows_of(WARP_ADDR, REG_ADDR, BANK_ADDR);
`ifdef RF_INIT_EN
  localparam rf_state_e RST_STATE = INIT;
`else
  localparam rf_state_e RST_STATE = IDLE;
`endif

  rf_state_e state_q, state_d;
  logic accept, conflict, init_last;

  logic [BW-1:0] bank_a, bank_b, bank_bq, bank_w;
  logic [RW-1:0] row_a, row_b, row_bq, row_w;

  logic [WARP_ADDR-1:0] warp_q;
  logic [REG_ADDR-1:0]  b_reg_q;
  logic [DATA-1:0]      a_hold_q, a_rd, b_rd;

  logic                 s1_valid_q;
  logic [DATA-1:0]      s1_a_q, s1_b_q;

  logic            bank_we    [NB];
  logic [RW-1:0]   bank_waddr [NB];
  logic [DATA-1:0] bank_wdata [NB];
  logic [RW-1:0]   bank_raddr [NB];
  logic [DATA-1:0] bank_rdata [NB];

  assign bank_a  = BW'(bank_of(int'(rd_warp), int'(rd_a_reg), BANK_ADDR));
  assign bank_b  = BW'(bank_of(int'(rd_warp), int'(rd_b_reg), BANK_ADDR));
  assign bank_bq = BW'(bank_of(int'(warp_q), int'(b_reg_q), BANK_ADDR));
  assign bank_w  = BW'(bank_of(int'(wr_warp), int'(wr_reg), BANK_ADDR));
  assign row_a   = RW'(row_of(int'(rd_warp), int'(rd_a_reg), REG_ADDR, BANK_ADDR));
  assign row_b   = RW'(row_of(int'(rd_warp), int'(rd_b_reg), REG_ADDR, BANK_ADDR));
  assign row_bq  = RW'(row_of(int'(warp_q), int'(b_reg_q), REG_ADDR, BANK_ADDR));
  assign row_w   = RW'(row_of(int'(wr_warp), int'(wr_reg), REG_ADDR, BANK_ADDR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (init_last) state_d = IDLE;
      IDLE:    if (accept && conflict) state_d = SECOND;
      SECOND:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_ready  = (state_q == IDLE) && !rst;
    init_done = (state_q != INIT) && !rst;
    accept    = rd_valid && rd_ready;
    conflict  = (bank_a == bank_b) && (rd_a_reg != rd_b_reg);
  end

`ifdef RF_INIT_EN
  logic [RW-1:0] init_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || (state_q != INIT)) begin
      init_cnt_q <= '0;
    end else begin
      init_cnt_q <= init_cnt_q + RW'(1);
    end
  end

  assign init_last = (init_cnt_q == RW'(ROWS - 1));
`else
  assign init_last = 1'b0;
`endif

  // On a conflict the B address is written first so the A address wins the shared port.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      bank_raddr[i] = '0;
    end
    if (state_q == SECOND) begin
      bank_raddr[bank_bq] = row_bq;
    end else begin
      bank_raddr[bank_b] = row_b;
      bank_raddr[bank_a] = row_a;
    end
  end

  always_comb begin
    a_rd = bank_rdata[bank_a];
    b_rd = (state_q == SECOND) ? bank_rdata[bank_bq] : bank_rdata[bank_b];
  end

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      bank_we[i]    = wr_en && (bank_w == BW'(i));
      bank_waddr[i] = row_w;
      bank_wdata[i] = wr_data;
`ifdef RF_INIT_EN
      if (state_q == INIT) begin
        bank_we[i]    = 1'b1;
        bank_waddr[i] = init_cnt_q;
        bank_wdata[i] = '0;
      end
`endif
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_bank
    rf_bank #(
      .DATA (DATA),
      .ROWS (ROWS),
      .AW   (RW)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[g]),
      .waddr (bank_waddr[g]),
      .wdata (bank_wdata[g]),
      .raddr (bank_raddr[g]),
      .rdata (bank_rdata[g])
    );
  end

  // A conflicted request parks its A operand until B is read one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      a_hold_q   <= '0;
      warp_q     <= '0;
      b_reg_q    <= '0;
    end else begin
      s1_valid_q <= 1'b0;
      if (state_q == SECOND) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= a_hold_q;
        s1_b_q     <= b_rd;
      end else if (accept && conflict) begin
        a_hold_q <= a_rd;
        warp_q   <= rd_warp;
        b_reg_q  <= rd_b_reg;
      end else if (accept) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= a_rd;
        s1_b_q     <= b_rd;
      end
    end
  end

  if (OREG != 0) begin : g_oreg
    logic            s2_valid_q;
    logic [DATA-1:0] s2_a_q, s2_b_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_a_q     <= '0;
        s2_b_q     <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_a_q <= s1_a_q;
          s2_b_q <= s1_b_q;
        end
      end
    end

    assign out_valid = s2_valid_q;
    assign out_a     = s2_a_q;
    assign out_b     = s2_b_q;
  end else begin : g_no_oreg
    assign out_valid = s1_valid_q;
    assign out_a     = s1_a_q;
    assign out_b     = s1_b_q;
  end

endmodule

// File: tb/tb_gpgpu_banked_rf.sv
// Scoreboard bench for gpgpu_banked_rf; expectations adapt when RF_INIT_EN is defined.
module tb_gpgpu_banked_rf;

  localparam int OREG   = 0;
  localparam int LAT_NC = 1 + OREG;
  localparam int LAT_C  = 2 + OREG;
`ifdef RF_INIT_EN
  localparam int INIT_CYCLES = 16;
`else
  localparam int INIT_CYCLES = 0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          due;
  } sb_entry_t;

  logic        clk;
  logic        rst;
  logic        rd_valid;
  logic        rd_ready;
  logic [1:0]  rd_warp;
  logic [2:0]  rd_a_reg;
  logic [2:0]  rd_b_reg;
  logic        out_valid;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        wr_en;
  logic [1:0]  wr_warp;
  logic [2:0]  wr_reg;
  logic [31:0] wr_data;
  logic        init_done;

  int        cyc = 0;
  int        n_compared = 0;
  int        n_mismatched = 0;
  sb_entry_t sb [$];
  sb_entry_t mon_e;

  gpgpu_banked_rf #(
    .DATA      (32),
    .WARP_ADDR (2),
    .REG_ADDR  (3),
    .BANK_ADDR (1),
    .OREG      (OREG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_warp   (rd_warp),
    .rd_a_reg  (rd_a_reg),
    .rd_b_reg  (rd_b_reg),
    .out_valid (out_valid),
    .out_a     (out_a),
    .out_b     (out_b),
    .wr_en     (wr_en),
    .wr_warp   (wr_warp),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .init_done (init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input logic rv, input int rw, input int ra, input int rb,
                               input logic we, input int ww, input int wreg, input logic [31:0] wd);
    rd_valid = rv;
    rd_warp  = 2'(rw);
    rd_a_reg = 3'(ra);
    rd_b_reg = 3'(rb);
    wr_en    = we;
    wr_warp  = 2'(ww);
    wr_reg   = 3'(wreg);
    wr_data  = wd;
    tick();
    rd_valid = 1'b0;
    wr_en    = 1'b0;
  endtask

  task automatic writeReg(input int w, input int r, input logic [31:0] d);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, w, r, d);
  endtask

  // Issues one read (optionally with a same-cycle write); a conflicted read leaves the bench in SECOND.
  task automatic readReq(input int w, input int a, input int b, input logic [31:0] ea, input logic [31:0] eb,
                         input logic conf, input logic we, input int ww, input int wreg, input logic [31:0] wd);
    sb_entry_t e;
    checkOutput("rd_ready_at_issue", 32'(rd_ready), 32'd1);
    e.a   = ea;
    e.b   = eb;
    e.due = cyc + (conf ? LAT_C : LAT_NC);
    sb.push_back(e);
    applyStimulus(1'b1, w, a, b, we, ww, wreg, wd);
    if (conf) checkOutput("rd_ready_in_second", 32'(rd_ready), 32'd0);
    else      checkOutput("rd_ready_after_nc", 32'(rd_ready), 32'd1);
  endtask

  task automatic releaseReset();
    int k;
    rst = 1'b0;
    #1;
    k = 0;
    while (!init_done && k < 64) begin
      tick();
      k++;
    end
    checkOutput("init_cycles", 32'(k), 32'(INIT_CYCLES));
    checkOutput("rd_ready_after_init", 32'(rd_ready), 32'd1);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_a", out_a, 32'd0);
    checkOutput("rst_out_b", out_b, 32'd0);
    checkOutput("rst_rd_ready", 32'(rd_ready), 32'd0);
    checkOutput("rst_init_done", 32'(init_done), 32'd0);
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_out_valid: got a=0x%0h b=0x%0h at cycle %0d, expected no output", out_a, out_b, cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("out_a", out_a, mon_e.a);
        checkOutput("out_b", out_b, mon_e.b);
        checkOutput("out_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      mon_e = sb.pop_front();
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL missing_out_valid: got none by cycle %0d, expected a=0x%0h b=0x%0h at cycle %0d", cyc, mon_e.a, mon_e.b, mon_e.due);
    end
  end

  initial begin
    rst      = 1'b1;
    rd_valid = 1'b0;
    rd_warp  = '0;
    rd_a_reg = '0;
    rd_b_reg = '0;
    wr_en    = 1'b0;
    wr_warp  = '0;
    wr_reg   = '0;
    wr_data  = '0;
    idle(3);
    checkResetOutputs();
    releaseReset();

`ifdef RF_INIT_EN
    readReq(3, 5, 6, 32'h0, 32'h0, 1'b0, 1'b0, 0, 0, 32'h0);
    idle(3);
`endif

    $display("[TB] non-conflict read, w1 r2/r3 in different banks");
    writeReg(1, 2, 32'h0000_AAAA);
    writeReg(1, 3, 32'h0000_BBBB);
    readReq(1, 2, 3, 32'h0000_AAAA, 32'h0000_BBBB, 1'b0, 1'b0, 0, 0, 32'h0);
    idle(3);
    checkOutput("hold_out_valid", 32'(out_valid), 32'd0);
    checkOutput("hold_out_a", out_a, 32'h0000_AAAA);
    checkOutput("hold_out_b", out_b, 32'h0000_BBBB);

    $display("[TB] same register for A and B");
    readReq(1, 2, 2, 32'h0000_AAAA, 32'h0000_AAAA, 1'b0, 1'b0, 0, 0, 32'h0);
    idle(3);

    $display("[TB] conflict read w0 r0/r2, then back-to-back request");
    writeReg(0, 0, 32'h11);
    writeReg(0, 2, 32'h22);
    readReq(0, 0, 2, 32'h11, 32'h22, 1'b1, 1'b0, 0, 0, 32'h0);
    tick();
    readReq(1, 2, 3, 32'h0000_AAAA, 32'h0000_BBBB, 1'b0, 1'b0, 0, 0, 32'h0);
    idle(3);

    $display("[TB] conflict in warp 3");
    writeReg(3, 1, 32'hCAFE);
    writeReg(3, 3, 32'hF00D);
    readReq(3, 1, 3, 32'hCAFE, 32'hF00D, 1'b1, 1'b0, 0, 0, 32'h0);
    tick();
    idle(3);

    $display("[TB] write-first bypass");
    writeReg(2, 4, 32'h5555);
    writeReg(2, 1, 32'h1234);
    readReq(2, 4, 1, 32'hDEAD, 32'h1234, 1'b0, 1'b1, 2, 4, 32'hDEAD);
    idle(3);

    $display("[TB] writes landing during a conflicted request");
    readReq(0, 0, 2, 32'h11, 32'h99, 1'b1, 1'b1, 0, 2, 32'h99);
    tick();
    idle(2);
    readReq(0, 0, 2, 32'h11, 32'h77, 1'b1, 1'b0, 0, 0, 32'h0);
    applyStimulus(1'b1, 1, 2, 3, 1'b1, 0, 2, 32'h77);
    idle(4);

    $display("[TB] reset during SECOND");
    checkOutput("rd_ready_before_abort", 32'(rd_ready), 32'd1);
    applyStimulus(1'b1, 0, 0, 2, 1'b0, 0, 0, 32'h0);
    rst = 1'b1;
    tick();
    checkResetOutputs();
    releaseReset();
    idle(4);

`ifdef RF_INIT_EN
    readReq(1, 2, 3, 32'h0, 32'h0, 1'b0, 1'b0, 0, 0, 32'h0);
`else
    readReq(1, 2, 3, 32'h0000_AAAA, 32'h0000_BBBB, 1'b0, 1'b0, 0, 0, 32'h0);
`endif
    idle(5);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
